// File: rtl/sum_accumulator_pkg.sv
// rtl/sum_accumulator_pkg.sv - shared widths, FSM state type and log2 helper
package sum_accumulator_pkg;

  // Defaults shared with the upstream registered 8-bit adder stage
  localparam int DEF_IN_W  = 9;
  localparam int DEF_ACC_W = 16;
  localparam int DEF_N     = 8;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_ACCUM = 2'd1,
    ST_HOLD  = 2'd2
  } state_t;

  // Ceiling log2; N is a power of two so this is exact
  function automatic int log2n(input int n);
    int r;
    r = 0;
    for (int i = 0; i < 31; i++) begin
      if ((1 << i) < n) r = i + 1;
    end
    return r;
  endfunction

endpackage

// File: rtl/sum_accumulator_acc_core.sv
// rtl/sum_accumulator_acc_core.sv - accumulator adder, sticky overflow and run counter
module sum_accumulator_acc_core
  import sum_accumulator_pkg::*;
#(
  parameter int IN_W  = DEF_IN_W,
  parameter int ACC_W = DEF_ACC_W,
  parameter int N     = DEF_N
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             i_clear,
  input  logic             i_en,
  input  logic [IN_W-1:0]  i_sum,
  output logic [ACC_W-1:0] o_acc_next,
  output logic             o_ovf_next,
  output logic             o_last
);

  localparam int LOG2N = log2n(N);
  localparam int CW    = LOG2N + 1;

  logic [ACC_W-1:0] r_acc;
  logic             r_ovf;
  logic [CW-1:0]    r_count;
  logic [ACC_W:0]   w_sum;

  // One extra bit catches the carry out of the accumulator's top bit
  assign w_sum      = {1'b0, r_acc} + {{(ACC_W + 1 - IN_W){1'b0}}, i_sum};
  assign o_acc_next = w_sum[ACC_W-1:0];
  assign o_ovf_next = r_ovf | w_sum[ACC_W];
  assign o_last     = (r_count == CW'(N - 1));

  // Accumulate on each accepted sum; clear wins at the start of a run
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_acc   <= '0;
      r_ovf   <= 1'b0;
      r_count <= '0;
    end else if (i_clear) begin
      r_acc   <= '0;
      r_ovf   <= 1'b0;
      r_count <= '0;
    end else if (i_en) begin
      r_acc   <= o_acc_next;
      r_ovf   <= o_ovf_next;
      r_count <= r_count + CW'(1);
    end
  end

endmodule

// File: rtl/sum_accumulator.sv
// rtl/sum_accumulator.sv - accumulates N adder sums and presents total/mean/overflow
module sum_accumulator
  import sum_accumulator_pkg::*;
#(
  parameter int IN_W  = DEF_IN_W,
  parameter int ACC_W = DEF_ACC_W,
  parameter int N     = DEF_N
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             start,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [IN_W-1:0]  in_sum,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [ACC_W-1:0] out_total,
  output logic [IN_W-1:0]  out_avg,
  output logic             out_ovf,
  output logic             busy
);

  localparam int LOG2N = log2n(N);

  state_t           r_state;
  logic             w_accept;
  logic             w_clear;
  logic [ACC_W-1:0] w_acc_next;
  logic             w_ovf_next;
  logic             w_last;
  logic [IN_W-1:0]  w_avg;

  // Handshake flags come from the registered state only
  assign in_ready  = (r_state == ST_ACCUM);
  assign out_valid = (r_state == ST_HOLD);
  assign busy      = (r_state != ST_IDLE);

  assign w_accept = in_valid & in_ready;
  assign w_clear  = (r_state == ST_IDLE) & start;

  // A wrapped accumulator makes the mean meaningless, so saturate it
  assign w_avg = w_ovf_next ? {IN_W{1'b1}} : IN_W'(w_acc_next >> LOG2N);

  sum_accumulator_acc_core #(
    .IN_W  (IN_W),
    .ACC_W (ACC_W),
    .N     (N)
  ) u_acc_core (
    .clk        (clk),
    .reset      (reset),
    .i_clear    (w_clear),
    .i_en       (w_accept),
    .i_sum      (in_sum),
    .o_acc_next (w_acc_next),
    .o_ovf_next (w_ovf_next),
    .o_last     (w_last)
  );

  // Run control; the result registers load on the edge of the final accept
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_state   <= ST_IDLE;
      out_total <= '0;
      out_avg   <= '0;
      out_ovf   <= 1'b0;
    end else begin
      case (r_state)
        ST_IDLE: begin
          if (start) r_state <= ST_ACCUM;
        end
        ST_ACCUM: begin
          if (w_accept && w_last) begin
            r_state   <= ST_HOLD;
            out_total <= w_acc_next;
            out_avg   <= w_avg;
            out_ovf   <= w_ovf_next;
          end
        end
        ST_HOLD: begin
          if (out_ready) r_state <= ST_IDLE;
        end
        default: r_state <= ST_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_sum_accumulator.sv
// tb/tb_sum_accumulator.sv - self-checking bench for sum_accumulator
module tb_sum_accumulator;

  localparam int IN_W  = 9;
  localparam int N     = 8;
  localparam int ACC_A = 16;
  localparam int ACC_B = 10;

  logic clk = 1'b0;
  logic reset = 1'b1;
  logic start = 1'b0;
  logic in_valid = 1'b0;
  logic out_ready = 1'b0;
  logic [IN_W-1:0] in_sum = '0;

  logic in_ready_a, out_valid_a, out_ovf_a, busy_a;
  logic [ACC_A-1:0] out_total_a;
  logic [IN_W-1:0] out_avg_a;
  logic in_ready_b, out_valid_b, out_ovf_b, busy_b;
  logic [ACC_B-1:0] out_total_b;
  logic [IN_W-1:0] out_avg_b;

  int n_cmp = 0;
  int n_err = 0;
  int run_q[$];

  always #5 clk = ~clk;

  sum_accumulator #(.IN_W(IN_W), .ACC_W(ACC_A), .N(N)) dut_a (
    .clk(clk), .reset(reset), .start(start), .in_valid(in_valid), .in_ready(in_ready_a),
    .in_sum(in_sum), .out_valid(out_valid_a), .out_ready(out_ready), .out_total(out_total_a),
    .out_avg(out_avg_a), .out_ovf(out_ovf_a), .busy(busy_a)
  );

  sum_accumulator #(.IN_W(IN_W), .ACC_W(ACC_B), .N(N)) dut_b (
    .clk(clk), .reset(reset), .start(start), .in_valid(in_valid), .in_ready(in_ready_b),
    .in_sum(in_sum), .out_valid(out_valid_b), .out_ready(out_ready), .out_total(out_total_b),
    .out_avg(out_avg_b), .out_ovf(out_ovf_b), .busy(busy_b)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  task automatic check_zero(input string tag);
    chk({tag, "_in_ready"},  32'(in_ready_a),  0);
    chk({tag, "_out_valid"}, 32'(out_valid_a), 0);
    chk({tag, "_busy"},      32'(busy_a),      0);
    chk({tag, "_total_a"},   32'(out_total_a), 0);
    chk({tag, "_avg_a"},     32'(out_avg_a),   0);
    chk({tag, "_ovf_a"},     32'(out_ovf_a),   0);
    chk({tag, "_total_b"},   32'(out_total_b), 0);
    chk({tag, "_ovf_b"},     32'(out_ovf_b),   0);
  endtask

  // Reference: plain sum of the run, reduced modulo each accumulator size
  task automatic check_result(input string tag);
    int total, ta, tb, aa, ab;
    bit oa, ob;
    total = 0;
    foreach (run_q[i]) total += run_q[i];
    oa = (total >= (1 << ACC_A));
    ob = (total >= (1 << ACC_B));
    ta = total % (1 << ACC_A);
    tb = total % (1 << ACC_B);
    aa = oa ? (1 << IN_W) - 1 : ta / N;
    ab = ob ? (1 << IN_W) - 1 : tb / N;
    chk({tag, "_total_a"}, 32'(out_total_a), ta);
    chk({tag, "_avg_a"},   32'(out_avg_a),   aa);
    chk({tag, "_ovf_a"},   32'(out_ovf_a),   32'(oa));
    chk({tag, "_total_b"}, 32'(out_total_b), tb);
    chk({tag, "_avg_b"},   32'(out_avg_b),   ab);
    chk({tag, "_ovf_b"},   32'(out_ovf_b),   32'(ob));
  endtask

  task automatic do_start();
    chk("idle_in_ready", 32'(in_ready_a), 0);
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    chk("start_in_ready", 32'(in_ready_a), 1);
    chk("start_busy", 32'(busy_a), 1);
  endtask

  task automatic feed(input int bubble_pct, input int start_at, input int stop_after);
    int acc_n, guard;
    bit pulsed;
    acc_n = 0;
    guard = 0;
    pulsed = 0;
    while (acc_n < stop_after && guard < 400) begin
      in_valid = ($urandom_range(99) >= bubble_pct);
      in_sum = IN_W'(run_q[acc_n]);
      start = (!pulsed && acc_n == start_at);
      if (start) pulsed = 1;
      chk("no_early_valid", 32'(out_valid_a), 0);
      if (in_valid && in_ready_a) acc_n++;
      @(negedge clk);
      guard++;
    end
    in_valid = 1'b0;
    start = 1'b0;
    chk("accept_count", acc_n, stop_after);
  endtask

  task automatic hold_phase(input int wait_n, input bit start_too);
    chk("hold_valid_a", 32'(out_valid_a), 1);
    chk("hold_valid_b", 32'(out_valid_b), 1);
    chk("hold_in_ready", 32'(in_ready_a), 0);
    check_result("result");
    for (int i = 0; i < wait_n; i++) begin
      in_valid = 1'b1;
      in_sum = IN_W'($urandom);
      @(negedge clk);
      chk("hold_stay_valid", 32'(out_valid_a), 1);
      check_result("hold_stable");
    end
    in_valid = 1'b0;
    out_ready = 1'b1;
    start = start_too;
    @(negedge clk);
    out_ready = 1'b0;
    start = 1'b0;
    chk("release_valid_a", 32'(out_valid_a), 0);
    chk("release_valid_b", 32'(out_valid_b), 0);
    chk("release_busy", 32'(busy_a), 0);
    @(negedge clk);
    chk("idle_after_release", 32'(busy_a), 0);
  endtask

  initial begin
    repeat (2) @(negedge clk);
    check_zero("reset");
    reset = 1'b0;
    @(negedge clk);

    // Basic run 1..8
    run_q = {1, 2, 3, 4, 5, 6, 7, 8};
    do_start();
    feed(0, -1, 8);
    chk("basic_total", 32'(out_total_a), 36);
    chk("basic_avg", 32'(out_avg_a), 4);
    chk("basic_ovf", 32'(out_ovf_a), 0);
    hold_phase(0, 0);

    // Max inputs; narrow instance wraps
    run_q = {511, 511, 511, 511, 511, 511, 511, 511};
    do_start();
    feed(0, -1, 8);
    chk("max_total", 32'(out_total_a), 4088);
    chk("max_avg", 32'(out_avg_a), 511);
    chk("max_ovf", 32'(out_ovf_a), 0);
    chk("wrap_total", 32'(out_total_b), 1016);
    chk("wrap_avg", 32'(out_avg_b), 511);
    chk("wrap_ovf", 32'(out_ovf_b), 1);
    hold_phase(2, 1);

    // Random data with bubbles and backpressure
    run_q.delete();
    for (int i = 0; i < N; i++) run_q.push_back(int'($urandom_range(511)));
    do_start();
    feed(30, -1, 8);
    hold_phase(5, 0);

    // Start pulsed mid-run after 3 accepts is ignored
    run_q.delete();
    for (int i = 0; i < N; i++) run_q.push_back(int'($urandom_range(511)));
    do_start();
    feed(20, 3, 8);
    hold_phase(1, 0);

    // Reset after 5 accepts, then a fresh run of 10s
    run_q.delete();
    for (int i = 0; i < N; i++) run_q.push_back(int'($urandom_range(1, 511)));
    do_start();
    feed(0, -1, 5);
    reset = 1'b1;
    #1;
    check_zero("midrun_reset");
    @(negedge clk);
    reset = 1'b0;
    @(negedge clk);
    run_q = {10, 10, 10, 10, 10, 10, 10, 10};
    do_start();
    feed(10, -1, 8);
    chk("after_reset_total", 32'(out_total_a), 80);
    hold_phase(0, 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
